// File: rtl/lighting_seq.sv
// lighting_seq: bounded up/down colour-code sequencer with level, edge,
// timed auto-advance and hold modes, plus a one-cycle wrap pulse that marks
// each full pass through [MIN_CODE, MAX_CODE].
module lighting_seq #(
    parameter int WIDTH    = 3,
    parameter int MIN_CODE = 1,
    parameter int MAX_CODE = 6,
    parameter int PERIOD   = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             button,
    input  logic             dir,
    input  logic [1:0]       mode,
    output logic [WIDTH-1:0] colour,
    output logic             wrap
);

    // Prescaler is never narrower than one bit so PERIOD=1 still elaborates.
    localparam int PW = (PERIOD > 1) ? $clog2(PERIOD) : 1;

    localparam logic [PW-1:0]    PRESC_LAST = PW'(PERIOD - 1);
    localparam logic [WIDTH-1:0] MIN_C      = WIDTH'(MIN_CODE);
    localparam logic [WIDTH-1:0] MAX_C      = WIDTH'(MAX_CODE);

    typedef enum logic [1:0] {
        MODE_LEVEL = 2'b00,
        MODE_EDGE  = 2'b01,
        MODE_AUTO  = 2'b10,
        MODE_HOLD  = 2'b11
    } mode_t;

    if ((MIN_CODE < 0) || (MIN_CODE >= MAX_CODE) ||
        (MAX_CODE > (2 ** WIDTH) - 1) || (PERIOD < 1)) begin : g_bad_params
        $error("lighting_seq: illegal WIDTH/MIN_CODE/MAX_CODE/PERIOD combination");
    end

    mode_t             mode_e;
    logic              btn_q;
    logic [PW-1:0]     presc;
    logic [PW-1:0]     presc_nxt;
    logic              step;
    logic              in_range;
    logic [WIDTH-1:0]  colour_nxt;
    logic              wrap_nxt;

    assign mode_e = mode_t'(mode);

    // Upward step with wrap from the top of the range back to the bottom.
    function automatic logic [WIDTH:0] step_up(input logic [WIDTH-1:0] c);
        if (c == MAX_C) begin
            return {1'b1, MIN_C};
        end
        return {1'b0, c + WIDTH'(1)};
    endfunction

    // Downward step with wrap from the bottom of the range back to the top.
    function automatic logic [WIDTH:0] step_down(input logic [WIDTH-1:0] c);
        if (c == MIN_C) begin
            return {1'b1, MAX_C};
        end
        return {1'b0, c - WIDTH'(1)};
    endfunction

    // Step decision, prescaler advance and next colour/wrap.
    always_comb begin
        step       = 1'b0;
        presc_nxt  = '0;
        colour_nxt = colour;
        wrap_nxt   = 1'b0;
        in_range   = (int'(colour) >= MIN_CODE) && (int'(colour) <= MAX_CODE);

        case (mode_e)
            MODE_LEVEL: step = button;
            MODE_EDGE:  step = button && !btn_q;
            MODE_AUTO: begin
                // Prescaler sits at 0 outside auto mode, so the first auto
                // step lands PERIOD edges after entering it.
                step = (presc == PRESC_LAST);
                if (presc != PRESC_LAST) begin
                    presc_nxt = presc + PW'(1);
                end
            end
            default:    step = 1'b0;
        endcase

        if (!in_range) begin
            colour_nxt = MIN_C;
        end else if (step) begin
            if (!dir) begin
                {wrap_nxt, colour_nxt} = step_up(colour);
            end else begin
                {wrap_nxt, colour_nxt} = step_down(colour);
            end
        end
    end

    // State registers; reset returns to the bottom of the range immediately.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            colour <= MIN_C;
            wrap   <= 1'b0;
            presc  <= '0;
            btn_q  <= 1'b0;
        end else begin
            colour <= colour_nxt;
            wrap   <= wrap_nxt;
            presc  <= presc_nxt;
            btn_q  <= button;
        end
    end

endmodule

// File: tb/tb_lighting_seq.sv
// Scoreboard bench for lighting_seq: a driver applies directed and random
// stimulus on the falling edge and queues the expected colour/wrap from a
// range-index reference model; a monitor compares after each rising edge.
module tb_lighting_seq;

    localparam int MIN_A = 1, MAX_A = 6,  PER_A = 4;
    localparam int MIN_B = 2, MAX_B = 13, PER_B = 1;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       button = 1'b0;
    logic       dir = 1'b0;
    logic       dir_b = 1'b0;
    logic [1:0] mode = 2'b00;
    logic [1:0] mode_b = 2'b10;
    logic [2:0] colour_a;
    logic       wrap_a;
    logic [3:0] colour_b;
    logic       wrap_b;

    int checks = 0;
    int failures = 0;

    typedef struct {
        int colour;
        bit wrap;
        int auto_cnt;
        bit prev_btn;
    } model_t;

    model_t ma;
    model_t mb;
    int q_a[$];
    int q_b[$];

    lighting_seq #(.WIDTH(3), .MIN_CODE(MIN_A), .MAX_CODE(MAX_A), .PERIOD(PER_A)) dut_a (
        .clk(clk), .rst(rst), .button(button), .dir(dir), .mode(mode),
        .colour(colour_a), .wrap(wrap_a)
    );

    lighting_seq #(.WIDTH(4), .MIN_CODE(MIN_B), .MAX_CODE(MAX_B), .PERIOD(PER_B)) dut_b (
        .clk(clk), .rst(rst), .button(button), .dir(dir_b), .mode(mode_b),
        .colour(colour_b), .wrap(wrap_b)
    );

    always #5 clk = ~clk;

    // Reference: colour is a position in a ring of (max-min+1) codes; auto
    // mode steps on every per-th consecutive edge spent in that mode.
    function automatic model_t model_next(model_t s, bit rst_n, bit btn, bit d,
                                          bit [1:0] md, int mn, int mx, int per);
        model_t n = s;
        int span = mx - mn + 1;
        int idx = s.colour - mn;
        bit step;
        n.wrap = 1'b0;
        if (!rst_n) begin
            n.colour = mn;
            n.auto_cnt = 0;
            n.prev_btn = 1'b0;
            return n;
        end
        n.auto_cnt = (md == 2'd2) ? s.auto_cnt + 1 : 0;
        case (md)
            2'd0:    step = btn;
            2'd1:    step = btn && !s.prev_btn;
            2'd2:    step = (n.auto_cnt % per) == 0;
            default: step = 1'b0;
        endcase
        n.prev_btn = btn;
        if (step) begin
            if (!d) begin
                n.colour = mn + (idx + 1) % span;
                n.wrap = (idx == span - 1);
            end else begin
                n.colour = mn + (idx + span - 1) % span;
                n.wrap = (idx == 0);
            end
        end
        return n;
    endfunction

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s at %0t: actual=%0d expected=%0d", name, $time, act, exp);
        end
    endtask

    // Apply one cycle of stimulus and queue the values expected after the next rising edge.
    task automatic drive(input bit r, input bit b, input bit d, input bit [1:0] m,
                         input bit db, input bit [1:0] mdb);
        @(negedge clk);
        rst = r;
        button = b;
        dir = d;
        mode = m;
        dir_b = db;
        mode_b = mdb;
        ma = model_next(ma, r, b, d, m, MIN_A, MAX_A, PER_A);
        mb = model_next(mb, r, b, db, mdb, MIN_B, MAX_B, PER_B);
        q_a.push_back(ma.colour * 2 + int'(ma.wrap));
        q_b.push_back(mb.colour * 2 + int'(mb.wrap));
    endtask

    // Monitor: every cycle presents an output; compare against the queue head.
    initial begin
        int e;
        forever begin
            @(posedge clk);
            #2;
            if (q_a.size() > 0) begin
                e = q_a.pop_front();
                check("colour_a", int'(colour_a), e / 2);
                check("wrap_a", int'(wrap_a), e % 2);
            end
            if (q_b.size() > 0) begin
                e = q_b.pop_front();
                check("colour_b", int'(colour_b), e / 2);
                check("wrap_b", int'(wrap_b), e % 2);
                check("range_b", int'((colour_b >= 4'(MIN_B)) && (colour_b <= 4'(MAX_B))), 1);
            end
        end
    end

    // Watchdog so the run always terminates.
    initial begin
        #200000;
        $display("FAIL watchdog: actual=timeout expected=finish");
        failures++;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog expired");
    end

    // Driver: directed scenarios followed by randomized mode/dir/button runs.
    initial begin
        bit [1:0] rm;
        bit [1:0] rmb;
        bit rd;
        bit rdb;
        int len;

        // Reset held, then released with no button: colour stays at the bottom.
        repeat (2) drive(0, 0, 0, 2'd0, 0, 2'd2);
        repeat (2) drive(1, 0, 0, 2'd0, 0, 2'd2);

        // Level mode upward through a wrap, then hold.
        repeat (7) drive(1, 1, 0, 2'd0, 0, 2'd2);
        repeat (3) drive(1, 0, 0, 2'd0, 0, 2'd2);

        // Reach colour 4, then assert reset between edges and check at once.
        repeat (2) drive(1, 1, 0, 2'd0, 0, 2'd2);
        drive(0, 0, 0, 2'd0, 0, 2'd2);
        #1;
        check("async_colour_a", int'(colour_a), MIN_A);
        check("async_wrap_a", int'(wrap_a), 0);
        check("async_colour_b", int'(colour_b), MIN_B);
        repeat (3) drive(1, 0, 0, 2'd0, 0, 2'd2);

        // Edge mode: one step per press regardless of length.
        repeat (5) drive(1, 1, 0, 2'd1, 0, 2'd2);
        drive(1, 0, 0, 2'd1, 0, 2'd2);
        repeat (4) drive(1, 1, 0, 2'd1, 0, 2'd2);
        repeat (2) drive(1, 0, 0, 2'd1, 0, 2'd2);

        // Back to colour 1, then level mode downward through a wrap and a dir flip.
        repeat (2) drive(1, 1, 1, 2'd0, 0, 2'd2);
        repeat (3) drive(1, 1, 1, 2'd0, 0, 2'd2);
        drive(1, 1, 0, 2'd0, 0, 2'd2);
        drive(1, 0, 0, 2'd0, 0, 2'd2);

        // Auto mode, hold mode with button pressed, then auto again.
        repeat (10) drive(1, 0, 0, 2'd2, 0, 2'd2);
        repeat (5) drive(1, 1, 0, 2'd3, 0, 2'd2);
        repeat (9) drive(1, 0, 0, 2'd2, 0, 2'd2);

        // Randomized segments for both instances, with occasional resets.
        for (int s = 0; s < 50; s++) begin
            rm = 2'($urandom_range(0, 3));
            rmb = 2'($urandom_range(0, 3));
            rd = 1'($urandom_range(0, 1));
            rdb = 1'($urandom_range(0, 1));
            len = $urandom_range(2, 20);
            for (int c = 0; c < len; c++) begin
                if ($urandom_range(0, 7) == 0) rd = ~rd;
                drive(($urandom_range(0, 63) != 0), 1'($urandom_range(0, 1)), rd, rm, rdb, rmb);
            end
        end

        repeat (2) drive(1, 0, 0, 2'd3, 0, 2'd3);
        repeat (3) @(negedge clk);
        check("queue_a_drained", q_a.size(), 0);
        check("queue_b_drained", q_b.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/lighting_seq.md
Name: lighting_seq

Overview:
Parametrised successor to the single-button LED colour sequencer. It drives a WIDTH-bit colour code that cycles through a bounded range [MIN_CODE, MAX_CODE], with selectable up/down direction. Four modes are available: level-advance, edge-step, timed auto-advance and hold. A one-cycle wrap pulse lets downstream effects logic synchronise to each full cycle of the sequence.

Parameters:
WIDTH, 3, width of colour code
MIN_CODE, 1, lowest legal colour (reset value; all-off excluded by default)
MAX_CODE, 6, highest legal colour (all-on excluded by default); require 0 <= MIN_CODE < MAX_CODE <= 2^WIDTH-1
PERIOD, 4, auto-mode step interval in clk cycles; require PERIOD >= 1; prescaler width = clog2(PERIOD), min 1

Ports:
clk  input  1  system clock, rising-edge
rst  input  1  asynchronous, active-low reset
button  input  1  advance request (level or edge depending on mode)
dir  input  1  0 = count up, 1 = count down
mode  input  2  00 level, 01 edge, 10 auto, 11 hold
colour  output  WIDTH  current colour code, registered
wrap  output  1  registered one-cycle pulse on range wrap

Behaviour:
- Reset (rst=0, asynchronous, no clock needed):
  - colour=MIN_CODE, wrap=0, prescaler=0, btn_q=0.
  - Reset held: outputs stay at these values.
  - Release: first step possible at the first rising clk after rst=1.
- btn_q: registered copy of button, updated every cycle in all modes.
- Step event, evaluated at each rising clk:
  - mode 00: step when button==1. Holds while button==0.
  - mode 01: step when button==1 && btn_q==0. One step per press however long it is held.
  - mode 10: step when prescaler==PERIOD-1. The prescaler then returns to 0, otherwise it increments. Button is ignored. With PERIOD=1, steps every cycle.
  - mode 11: no steps, colour frozen.
- Prescaler:
  - Counts only in mode 10.
  - Cleared to 0 in any other mode, and on the cycle the mode changes into 10.
  - First auto step comes PERIOD cycles after entering mode 10.
- Step arithmetic, dir sampled on the same edge:
  - up: colour==MAX_CODE -> MIN_CODE with wrap=1; else colour+1.
  - down: colour==MIN_CODE -> MAX_CODE with wrap=1; else colour-1.
  - Arithmetic is WIDTH bits, no overflow past range.
- wrap:
  - High for exactly the cycle in which colour holds the wrapped value.
  - 0 on every non-wrapping cycle, including consecutive non-step cycles.
- dir change between steps takes effect on the next step. There is no extra latency.
- Out-of-range recovery: if colour is ever outside [MIN_CODE, MAX_CODE], the next clk forces colour=MIN_CODE with wrap=0, regardless of mode.
- Latency:
  - colour updates on the same rising edge the step condition is sampled.
  - That is one cycle from a button change to colour change in modes 00/01.
- Mode change mid-operation: colour is preserved and only the stepping rule changes.

Test Plan:
1. Async reset: with colour=4, drive rst=0 between clock edges -> colour=1 and wrap=0 immediately. Release rst; with button=0 and mode=00, colour stays 1.
2. Level mode up: mode=00, dir=0, button=1 for 7 cycles from colour=1 -> 2,3,4,5,6,1(wrap=1),2. wrap=0 on all other cycles. Then button=0 -> colour holds 2.
3. Edge mode: mode=01, button high for 5 cycles -> single step 1->2. Button low 1 cycle, then high -> 3. Button held never produces 4.
4. Down direction wrap: mode=00, dir=1, button=1 from colour=1 -> 6 (wrap=1), 5, 4. Flip dir=0 mid-run -> next value 5.
5. Auto mode, PERIOD=4: switch to mode=10 at colour=1 -> colour 1 for 4 cycles, then 2, then 3 after 4 more. Switch to mode=11 -> colour frozen, button ignored. Re-enter mode 10 -> next step exactly 4 cycles later.
6. Parameter instance WIDTH=4, MIN_CODE=2, MAX_CODE=13, PERIOD=1, mode=10, dir=0 -> reset value 2, steps every cycle, 13->2 with wrap=1, and never shows 0,1,14,15.
